// File: rtl/weight_mem_sched.sv
// Read/write scheduler for one dual-port weight BRAM: round-robin burst reads
// for two requesters plus single-word loads from the weight loader.
module weight_mem_sched #(
  parameter int unsigned RAM_WIDTH = 16,
  parameter int unsigned RAM_DEPTH = 400,
  parameter int unsigned RAM_ADDR  = 9,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [RAM_ADDR-1:0]  req0_base,
  input  logic [RAM_ADDR-1:0]  req0_len,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [RAM_ADDR-1:0]  req1_base,
  input  logic [RAM_ADDR-1:0]  req1_len,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [RAM_ADDR-1:0]  ld_addr,
  input  logic [RAM_WIDTH-1:0] ld_data,
  output logic                 mem_ce0,
  output logic [RAM_ADDR-1:0]  mem_addr0,
  input  logic [RAM_WIDTH-1:0] mem_wout,
  output logic                 mem_ce1,
  output logic                 mem_we1,
  output logic [RAM_ADDR-1:0]  mem_addr1,
  output logic [RAM_WIDTH-1:0] mem_win,
  output logic [RAM_WIDTH-1:0] rd_data,
  output logic                 rd_valid,
  output logic                 rd_id,
  output logic                 rd_last,
  output logic                 done0,
  output logic                 done1,
  output logic                 err,
  output logic                 busy
);

  localparam logic [RAM_ADDR-1:0] LAST_ADDR  = RAM_ADDR'(RAM_DEPTH - 1);
  localparam logic [RAM_ADDR-1:0] DRAIN_INIT = RAM_ADDR'(RD_LAT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [RAM_ADDR-1:0] cnt_q, cnt_d;
  logic [RAM_ADDR-1:0] addr_q, addr_d;
  logic                id_q, id_d;
  logic                last_q, last_d;
  logic [1:0]          done_imm_q, done_imm_d;
  logic                err_q, err_d;

  // Tag pipe travelling alongside each read, RD_LAT stages deep
  logic [RD_LAT-1:0]   tv_q, ti_q, tl_q;

  logic                gnt;
  logic [RAM_ADDR-1:0] g_base;
  logic [RAM_ADDR-1:0] g_len;
  logic                issue;
  logic                issue_last;

  assign issue      = (state_q == BURST);
  assign issue_last = issue && (cnt_q == RAM_ADDR'(1));

  // Next-state, arbitration and write-port decode
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    id_d       = id_q;
    last_d     = last_q;
    done_imm_d = 2'b00;
    err_d      = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    ld_ready   = 1'b0;
    mem_ce1    = 1'b0;
    mem_we1    = 1'b0;
    mem_addr1  = '0;
    mem_win    = '0;
    gnt        = 1'b0;
    g_base     = '0;
    g_len      = '0;

    case (state_q)
      IDLE: begin
        if (ld_valid) begin
          ld_ready  = 1'b1;
          mem_ce1   = 1'b1;
          mem_we1   = 1'b1;
          mem_addr1 = ld_addr;
          mem_win   = ld_data;
        end else if (req0_valid || req1_valid) begin
          // on a tie the requester not granted last time wins
          gnt        = (req0_valid && req1_valid) ? ~last_q : req1_valid;
          g_base     = gnt ? req1_base : req0_base;
          g_len      = gnt ? req1_len  : req0_len;
          req0_ready = ~gnt;
          req1_ready = gnt;
          last_d     = gnt;
          id_d       = gnt;
          if (g_len == '0) begin
            done_imm_d[gnt] = 1'b1;
          end else if (32'(g_base) >= RAM_DEPTH) begin
            err_d           = 1'b1;
            done_imm_d[gnt] = 1'b1;
          end else begin
            state_d = BURST;
            addr_d  = g_base;
            cnt_d   = g_len;
          end
        end
      end
      BURST: begin
        if (cnt_q == RAM_ADDR'(1)) begin
          // address holds at the final issued word
          state_d = DRAIN;
          cnt_d   = DRAIN_INIT;
        end else begin
          cnt_d  = cnt_q - RAM_ADDR'(1);
          addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + RAM_ADDR'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - RAM_ADDR'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      id_q       <= 1'b0;
      last_q     <= 1'b1;
      done_imm_q <= 2'b00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      id_q       <= id_d;
      last_q     <= last_d;
      done_imm_q <= done_imm_d;
      err_q      <= err_d;
    end
  end

  // Tag pipe shift: stage 0 captures the tag of the read issued this cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv_q <= '0;
      ti_q <= '0;
      tl_q <= '0;
    end else begin
      tv_q[0] <= issue;
      ti_q[0] <= id_q;
      tl_q[0] <= issue_last;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        tv_q[i] <= tv_q[i-1];
        ti_q[i] <= ti_q[i-1];
        tl_q[i] <= tl_q[i-1];
      end
    end
  end

  assign mem_ce0   = issue;
  assign mem_addr0 = addr_q;
  assign rd_valid  = tv_q[RD_LAT-1];
  assign rd_id     = tv_q[RD_LAT-1] & ti_q[RD_LAT-1];
  assign rd_last   = tv_q[RD_LAT-1] & tl_q[RD_LAT-1];
  assign rd_data   = rd_valid ? mem_wout : '0;
  assign done0     = done_imm_q[0] | (rd_last & ~rd_id);
  assign done1     = done_imm_q[1] | (rd_last &  rd_id);
  assign err       = err_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_weight_mem_sched.sv
// Directed bench for weight_mem_sched with a behavioural BRAM alongside.
module tb_weight_mem_sched;

  localparam int unsigned W = 16;
  localparam int unsigned D = 400;
  localparam int unsigned A = 9;
  localparam int unsigned L = 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req0_ready, req1_valid, req1_ready;
  logic [A-1:0] req0_base, req0_len, req1_base, req1_len;
  logic         ld_valid, ld_ready;
  logic [A-1:0] ld_addr;
  logic [W-1:0] ld_data;
  logic         mem_ce0, mem_ce1, mem_we1;
  logic [A-1:0] mem_addr0, mem_addr1;
  logic [W-1:0] mem_wout, mem_win, rd_data;
  logic         rd_valid, rd_id, rd_last, done0, done1, err, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [W-1:0] ram    [D];
  logic [W-1:0] shadow [D];

  always #5 clk = ~clk;

  weight_mem_sched #(.RAM_WIDTH(W), .RAM_DEPTH(D), .RAM_ADDR(A), .RD_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_base(req0_base), .req0_len(req0_len),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_base(req1_base), .req1_len(req1_len),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .mem_ce0(mem_ce0), .mem_addr0(mem_addr0), .mem_wout(mem_wout),
    .mem_ce1(mem_ce1), .mem_we1(mem_we1), .mem_addr1(mem_addr1), .mem_win(mem_win),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_id(rd_id), .rd_last(rd_last),
    .done0(done0), .done1(done1), .err(err), .busy(busy)
  );

  // Behavioural BRAM, one-cycle registered read
  always @(posedge clk) begin
    if (mem_ce1 && mem_we1) ram[mem_addr1] <= mem_win;
    if (mem_ce0) mem_wout <= ram[mem_addr0];
  end

  typedef struct {
    logic sel;
    int   base;
    int   len;
    int   exp_ce0;
    int   exp_err;
    int   exp_last_addr;
  } rec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one burst request and follow it until the scheduler is idle again
  task automatic run_burst(input rec_t r);
    int   ce_n, rv_n, dn_n, odn_n, er_n, exp_addr, widx, exp_d;
    int   q[$];
    logic seen;
    ce_n = 0; rv_n = 0; dn_n = 0; odn_n = 0; er_n = 0; widx = 0;
    exp_addr = r.base;
    seen = 1'b0;
    @(negedge clk);
    if (r.sel) begin
      req1_valid = 1'b1; req1_base = A'(r.base); req1_len = A'(r.len);
    end else begin
      req0_valid = 1'b1; req0_base = A'(r.base); req0_len = A'(r.len);
    end
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (r.sel ? req1_ready : req0_ready) seen = 1'b1;
      else @(negedge clk);
    end
    chk("grant_seen", int'(seen), 1);
    chk("other_ready", int'(r.sel ? req0_ready : req1_ready), 0);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    if (!seen) return;
    for (int k = 0; k < r.len + int'(L) + 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      if (mem_ce0) begin
        ce_n++;
        chk("rd_addr", int'(mem_addr0), exp_addr);
        q.push_back(int'(shadow[exp_addr]));
        exp_addr = (exp_addr == int'(D) - 1) ? 0 : exp_addr + 1;
      end
      if (rd_valid) begin
        rv_n++;
        exp_d = (q.size() > 0) ? q.pop_front() : -1;
        chk("rd_data", int'(rd_data), exp_d);
        chk("rd_id", int'(rd_id), int'(r.sel));
        chk("rd_last", int'(rd_last), int'(widx == r.len - 1));
        widx++;
      end
      if (r.sel ? done1 : done0) begin
        dn_n++;
        if (r.exp_ce0 > 0) chk("done_with_last", int'(rd_valid && rd_last), 1);
      end
      if (r.sel ? done0 : done1) odn_n++;
      if (err) begin
        er_n++;
        chk("err_with_done", int'(r.sel ? done1 : done0), 1);
      end
    end
    chk("ce0_count", ce_n, r.exp_ce0);
    chk("rd_valid_count", rv_n, r.exp_ce0);
    chk("done_count", dn_n, 1);
    chk("other_done_count", odn_n, 0);
    chk("err_count", er_n, r.exp_err);
    chk("busy_end", int'(busy), 0);
    if (r.exp_last_addr >= 0) chk("addr0_hold", int'(mem_addr0), r.exp_last_addr);
  endtask

  rec_t tbl[7];
  int   order[$];
  int   owner;
  int   alt_exp[4];
  int   nv;
  logic found;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{sel: 1'b0, base: 10,  len: 4, exp_ce0: 4, exp_err: 0, exp_last_addr: 13};
    tbl[1] = '{sel: 1'b1, base: 398, len: 4, exp_ce0: 4, exp_err: 0, exp_last_addr: 1};
    tbl[2] = '{sel: 1'b0, base: 5,   len: 0, exp_ce0: 0, exp_err: 0, exp_last_addr: -1};
    tbl[3] = '{sel: 1'b1, base: 450, len: 3, exp_ce0: 0, exp_err: 1, exp_last_addr: -1};
    tbl[4] = '{sel: 1'b1, base: 100, len: 1, exp_ce0: 1, exp_err: 0, exp_last_addr: 100};
    tbl[5] = '{sel: 1'b0, base: 399, len: 2, exp_ce0: 2, exp_err: 0, exp_last_addr: 0};
    tbl[6] = '{sel: 1'b0, base: 60,  len: 3, exp_ce0: 3, exp_err: 0, exp_last_addr: 62};
    alt_exp = '{0, 1, 0, 1};

    for (int i = 0; i < int'(D); i++) begin
      ram[i]    = W'(i);
      shadow[i] = W'(i);
    end
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_base = '0; req0_len = '0;
    req1_valid = 1'b0; req1_base = '0; req1_len = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ce0", int'(mem_ce0), 0);
    chk("rst_addr0", int'(mem_addr0), 0);
    chk("rst_rd_valid", int'(rd_valid), 0);
    chk("rst_done0", int'(done0), 0);
    chk("rst_done1", int'(done1), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ce1", int'(mem_ce1), 0);
    rst_n = 1'b1;

    // Round-robin: both requesting continuously, req0 wins first after reset
    @(negedge clk);
    req0_valid = 1'b1; req0_base = A'(30);  req0_len = A'(2);
    req1_valid = 1'b1; req1_base = A'(200); req1_len = A'(2);
    owner = -1;
    for (int i = 0; i < 60 && order.size() < 4; i++) begin
      #1;
      if (req0_ready && req1_ready) chk("dual_grant", 1, 0);
      if (req0_ready || req1_ready) begin
        chk("grant_while_idle", int'(busy), 0);
        owner = int'(req1_ready);
        order.push_back(owner);
      end
      if (rd_valid) chk("alt_rd_id", int'(rd_id), owner);
      @(negedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("alt_grant_count", order.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("alt_order", (i < order.size()) ? order[i] : -1, alt_exp[i]);
    end
    for (int i = 0; i < 20 && busy; i++) begin
      #1;
      if (rd_valid) chk("alt_rd_id", int'(rd_id), owner);
      @(negedge clk);
    end
    chk("alt_idle", int'(busy), 0);

    // Table of single bursts, including wrap, len=0 and bad base
    for (int i = 0; i < 6; i++) run_burst(tbl[i]);

    // Load and request together: load goes first, read returns the new word
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = A'(20); ld_data = 16'hBEEF;
    req0_valid = 1'b1; req0_base = A'(20); req0_len = A'(1);
    #1;
    chk("ld_ready", int'(ld_ready), 1);
    chk("ld_ce1", int'(mem_ce1), 1);
    chk("ld_we1", int'(mem_we1), 1);
    chk("ld_addr1", int'(mem_addr1), 20);
    chk("ld_win", int'(mem_win), 16'hBEEF);
    chk("ld_req0_held", int'(req0_ready), 0);
    shadow[20] = 16'hBEEF;
    @(negedge clk);
    ld_valid = 1'b0;
    #1;
    chk("ld_then_grant", int'(req0_ready), 1);
    chk("ld_ce1_off", int'(mem_ce1), 0);
    @(negedge clk);
    req0_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (rd_valid) begin
        found = 1'b1;
        chk("readback", int'(rd_data), int'(shadow[20]));
      end
      @(negedge clk);
    end
    chk("readback_seen", int'(found), 1);

    // Reset at the second word of a len=8 burst
    @(negedge clk);
    req0_valid = 1'b1; req0_base = A'(50); req0_len = A'(8);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      #1;
      if (req0_ready) found = 1'b1;
      @(negedge clk);
    end
    req0_valid = 1'b0;
    chk("rst_burst_grant", int'(found), 1);
    nv = 0;
    for (int i = 0; i < 20 && nv < 2; i++) begin
      #1;
      if (rd_valid) nv++;
      if (nv < 2) @(negedge clk);
    end
    chk("rst_second_word", nv, 2);
    rst_n = 1'b0;
    #1;
    chk("abort_rd_valid", int'(rd_valid), 0);
    chk("abort_rd_data", int'(rd_data), 0);
    chk("abort_rd_last", int'(rd_last), 0);
    chk("abort_done0", int'(done0), 0);
    chk("abort_ce0", int'(mem_ce0), 0);
    chk("abort_addr0", int'(mem_addr0), 0);
    chk("abort_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("post_rst_quiet", int'(rd_valid | mem_ce0 | busy | done0 | done1), 0);
      @(negedge clk);
    end
    run_burst(tbl[6]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
